// File: rtl/mmio_input_port.sv
// Memory-mapped input port: synchronizes switches and keys, debounces keys,
// latches key-press events, and answers loads with a one-cycle response.
module mmio_input_port #(
    parameter int          DEB_CYCLES  = 50000,
    parameter logic [9:0]  ADDR_SW     = 10'h3F0,
    parameter logic [9:0]  ADDR_KEYLVL = 10'h3F1,
    parameter logic [9:0]  ADDR_KEYEVT = 10'h3F2
) (
    input  logic        I_CLOCK,
    input  logic        I_LOCK,
    input  logic [9:0]  I_SW,
    input  logic [3:0]  I_KEY,
    input  logic        I_ReadEn,
    input  logic [9:0]  I_Addr,
    output logic        O_Hit,
    output logic        O_ReadValid,
    output logic [15:0] O_ReadData,
    output logic        O_KeyIrq
);

    localparam logic [15:0] DEB_MAX = 16'(DEB_CYCLES - 1);

    logic [9:0]  sw_meta_reg, sw_sync_reg;
    logic [3:0]  key_meta_reg, key_sync_reg;
    logic [3:0]  stable_key_reg, stable_key_next, stable_dly_reg;
    logic [3:0]  evt_reg, evt_next, press, clr;
    logic        irq_reg;
    logic        read_valid_reg;
    logic [15:0] read_data_reg, read_data_next;
    logic        read_fire;

    assign O_Hit     = (I_Addr == ADDR_SW) || (I_Addr == ADDR_KEYLVL) || (I_Addr == ADDR_KEYEVT);
    assign read_fire = I_ReadEn && O_Hit;

    // Two-stage synchronizers; keys reset to the released (high) level.
    always_ff @(negedge I_CLOCK) begin
        if (!I_LOCK) begin
            sw_meta_reg  <= '0;
            sw_sync_reg  <= '0;
            key_meta_reg <= 4'hF;
            key_sync_reg <= 4'hF;
        end else begin
            sw_meta_reg  <= I_SW;
            sw_sync_reg  <= sw_meta_reg;
            key_meta_reg <= I_KEY;
            key_sync_reg <= key_meta_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_deb
            logic [15:0] cnt_reg, cnt_next;
            logic        differ;

            // Count consecutive differing cycles; accept on the DEB_CYCLES-th one.
            assign differ              = key_sync_reg[gi] != stable_key_reg[gi];
            assign stable_key_next[gi] = (differ && cnt_reg == DEB_MAX) ? key_sync_reg[gi]
                                                                        : stable_key_reg[gi];
            assign cnt_next            = (differ && cnt_reg != DEB_MAX) ? cnt_reg + 16'd1 : 16'd0;

            always_ff @(negedge I_CLOCK) begin
                if (!I_LOCK) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end
        end
    endgenerate

    assign press    = stable_dly_reg & ~stable_key_reg;
    assign clr      = (read_fire && I_Addr == ADDR_KEYEVT) ? evt_reg : 4'h0;
    assign evt_next = (evt_reg & ~clr) | press;

    always_comb begin
        read_data_next = read_data_reg;
        if (read_fire) begin
            if (I_Addr == ADDR_SW) begin
                read_data_next = {6'b0, sw_sync_reg};
            end else if (I_Addr == ADDR_KEYLVL) begin
                read_data_next = {12'b0, ~stable_key_reg};
            end else begin
                read_data_next = {12'b0, evt_reg};
            end
        end
    end

    always_ff @(negedge I_CLOCK) begin
        if (!I_LOCK) begin
            stable_key_reg <= 4'hF;
            stable_dly_reg <= 4'hF;
            evt_reg        <= '0;
            irq_reg        <= 1'b0;
            read_valid_reg <= 1'b0;
            read_data_reg  <= '0;
        end else begin
            stable_key_reg <= stable_key_next;
            stable_dly_reg <= stable_key_reg;
            evt_reg        <= evt_next;
            irq_reg        <= |evt_next;
            read_valid_reg <= read_fire;
            read_data_reg  <= read_data_next;
        end
    end

    assign O_ReadValid = read_valid_reg;
    assign O_ReadData  = read_data_reg;
    assign O_KeyIrq    = irq_reg;

endmodule

// File: tb/tb_mmio_input_port.sv
// Directed bench for mmio_input_port with a rule-level model checked every cycle.
module tb_mmio_input_port;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        lock;
    logic [9:0]  sw;
    logic [3:0]  key;
    logic        ren;
    logic [9:0]  addr;
    logic        hit, valid, irq;
    logic [15:0] data;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    mmio_input_port #(.DEB_CYCLES(DEB)) dut (
        .I_CLOCK(clk), .I_LOCK(lock), .I_SW(sw), .I_KEY(key),
        .I_ReadEn(ren), .I_Addr(addr), .O_Hit(hit),
        .O_ReadValid(valid), .O_ReadData(data), .O_KeyIrq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_mapped(input logic [9:0] a);
        return a == 10'h3F0 || a == 10'h3F1 || a == 10'h3F2;
    endfunction

    // Model: inputs delayed by two samples, keys accepted after DEB differing samples.
    logic [9:0]  m_sw1, m_sw2;
    logic [3:0]  m_k1, m_k2, m_stable, m_prev, m_evt;
    int          m_run [4];
    logic        m_valid, m_irq;
    logic [15:0] m_data;

    always @(negedge clk) begin
        logic       nv;
        logic [3:0] clr_v, press_v;
        if (!lock) begin
            m_sw1 = '0; m_sw2 = '0;
            m_k1 = 4'hF; m_k2 = 4'hF; m_stable = 4'hF; m_prev = 4'hF;
            m_evt = '0; m_valid = 1'b0; m_irq = 1'b0; m_data = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            nv = ren && is_mapped(addr);
            if (nv) begin
                case (addr)
                    10'h3F0: m_data = {6'b0, m_sw2};
                    10'h3F1: m_data = {12'b0, ~m_stable};
                    default: m_data = {12'b0, m_evt};
                endcase
            end
            clr_v   = (nv && addr == 10'h3F2) ? m_evt : 4'h0;
            press_v = m_prev & ~m_stable;
            m_evt   = (m_evt & ~clr_v) | press_v;
            m_valid = nv;
            m_irq   = m_evt != 4'h0;
            m_prev  = m_stable;
            for (int i = 0; i < 4; i++) begin
                if (m_k2[i] != m_stable[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_stable[i] = m_k2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_sw2 = m_sw1; m_sw1 = sw;
            m_k2  = m_k1;  m_k1  = key;
        end
    end

    always @(posedge clk) begin
        if (check_en) begin
            chk("cyc_valid", valid, m_valid);
            chk("cyc_data", data, m_data);
            chk("cyc_irq", irq, m_irq);
            chk("cyc_hit", hit, is_mapped(addr));
        end
    end

    initial begin
        lock = 1'b0; ren = 1'b0; addr = '0; key = 4'h0; sw = 10'h3FF;
        repeat (3) tick;
        check_en = 1'b1;
        chk("rst_valid", valid, 1'b0);
        chk("rst_data", data, 16'h0000);
        chk("rst_irq", irq, 1'b0);
        lock = 1'b1; key = 4'hF;
        ren = 1'b1; addr = 10'h3F2;
        tick;
        ren = 1'b0;
        chk("rst_evt_read", data, 16'h0000);
        chk("rst_evt_valid", valid, 1'b1);

        // Switch read followed back-to-back by a key level read.
        sw = 10'h2A5;
        repeat (2) tick;
        ren = 1'b1; addr = 10'h3F0;
        #1 chk("sw_hit", hit, 1'b1);
        tick;
        chk("sw_valid", valid, 1'b1);
        chk("sw_data", data, 16'h02A5);
        addr = 10'h3F1;
        tick;
        ren = 1'b0;
        chk("b2b_valid", valid, 1'b1);
        chk("b2b_data", data, 16'h0000);
        tick;
        chk("b2b_drop", valid, 1'b0);

        // Glitches shorter than the debounce window are ignored.
        key = 4'hE; repeat (3) tick;
        key = 4'hF; repeat (2) tick;
        key = 4'hE; repeat (3) tick;
        key = 4'hF; repeat (8) tick;
        chk("glitch_irq", irq, 1'b0);
        key = 4'hE;
        repeat (6) tick;
        chk("hold_irq_6", irq, 1'b0);
        tick;
        chk("hold_irq_7", irq, 1'b1);
        repeat (3) tick;
        ren = 1'b1; addr = 10'h3F1;
        tick;
        ren = 1'b0;
        chk("keylvl_data", data, 16'h0001);

        // Read-to-clear, then a second read sees nothing pending.
        ren = 1'b1; addr = 10'h3F2;
        tick;
        chk("clr_data", data, 16'h0001);
        chk("clr_irq", irq, 1'b0);
        tick;
        ren = 1'b0;
        chk("clr_again", data, 16'h0000);

        // Re-arm key0, then land a key1 press on the same edge as a clearing read.
        key = 4'hF; repeat (8) tick;
        key = 4'hE; repeat (7) tick;
        chk("rearm_irq", irq, 1'b1);
        key = 4'hC;
        repeat (6) tick;
        ren = 1'b1; addr = 10'h3F2;
        tick;
        ren = 1'b0;
        chk("simul_data", data, 16'h0001);
        chk("simul_irq", irq, 1'b1);
        ren = 1'b1;
        tick;
        ren = 1'b0;
        chk("simul_evt", data, 16'h0002);

        // Unmapped address: no response, data held.
        ren = 1'b1; addr = 10'h3FC;
        #1 chk("miss_hit", hit, 1'b0);
        tick;
        ren = 1'b0;
        chk("miss_valid", valid, 1'b0);
        chk("miss_data", data, 16'h0002);

        // Reset during a key2 debounce discards the partial count.
        key = 4'hF; repeat (8) tick;
        key = 4'hB; repeat (3) tick;
        lock = 1'b0; tick;
        lock = 1'b1;
        chk("mid_rst_irq", irq, 1'b0);
        repeat (6) tick;
        chk("mid_rst_irq_6", irq, 1'b0);
        tick;
        chk("mid_rst_irq_7", irq, 1'b1);
        ren = 1'b1; addr = 10'h3F2;
        tick;
        ren = 1'b0;
        chk("mid_rst_evt", data, 16'h0004);
        repeat (2) tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
